fb_line_scheduler: RTL and testbench
====================================

# fb_line_scheduler

Arbitrates the single shared frame-memory port between the display line prefetcher and the incoming video-stream writer, and feeds the VGA core's `pixstream` input from an internal ping-pong line buffer. For each line the display is scanning, the block fetches the next line from frame memory into the idle half of the buffer. Stream writes get every memory slot the fetch leaves unused, plus a guaranteed slot every `FETCH_SLICE` reads.

## Interface
Parameters:
- `HRES`, 800: visible pixels per line.
- `VRES`, 600: visible lines.
- `VTOTAL`, 628: total lines per frame, including blanking.
- `ADDR_W`, 19: frame-memory word address width.
- `DATA_W`, 12: pixel width, packed as {b[3:0], g[3:0], r[3:0]}.
- `READ_LAT`, 2: fixed memory read latency in cycles.
- `FETCH_SLICE`, 8: number of consecutive fetch reads after which one write slot is offered.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `hread` in 11: current column from the VGA core.
- `vread` in 11: current line from the VGA core.
- `pixstream` out 12: pixel for (`vread`, `hread`), registered.
- `wr_valid` in 1: stream write request.
- `wr_ready` out 1: write accepted this cycle.
- `wr_addr` in ADDR_W: stream write address.
- `wr_data` in DATA_W: stream write data.
- `mem_ready` in 1: memory accepts a request this cycle.
- `mem_req` out 1: memory request strobe.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: read data, valid exactly `READ_LAT` cycles after an accepted read.
- `fetch_busy` out 1: fetch in progress.
- `underrun` out 1: sticky flag; cleared only by reset.

## Operation
- **Line start:** `line_start` = (`hread`==0) && (`hread_q`!=0). `hread_q` is the registered `hread` and resets to 11'h7FF.
- **Next line:** `next_line` = (`vread`==VTOTAL-1) ? 0 : `vread`+1.
- **FSM states:** IDLE, FETCH.
  - IDLE→FETCH on `line_start` when `next_line` < VRES. Load `base` = `next_line`*HRES, `col`=0, `dst` = `next_line`[0]. Bump the generation tag `gen`.
  - FETCH: when `mem_ready` and the slot is a fetch slot, issue a read at `base`+`col`, then `col`++.
  - FETCH→IDLE once `col`==HRES, i.e. all reads are issued.
- **Return pipe:** a shift pipe of depth READ_LAT carries {valid, gen, dst, col}. On exit, if valid and gen == current `gen`, write `mem_rdata` into buffer[`dst`][`col`]. Otherwise the return is discarded.
- **Completion:** `done_cnt` counts accepted returns for the current `gen`.
- **Slot arbitration in FETCH:** fetch has priority. After FETCH_SLICE consecutive issued reads, the next `mem_ready` cycle is a write slot if `wr_valid`; the slice counter then clears. If `wr_valid` is low, the slot goes back to fetch.
- **Slot arbitration in IDLE:** every `mem_ready` cycle is a write slot.
- **Write slot:** `wr_ready`=1, `mem_req`=1, `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`. `wr_ready` depends only on state, slot and `mem_ready`, never on `wr_valid`.
- **Display read:** `pixstream` <= buffer[`vread`[0]][`hread`] when `hread` < HRES, else 0.
- **Underrun:** `line_start` while `done_cnt` < HRES for an active fetch sets `underrun`. The fetch is then abandoned: `gen` bumps, in-flight returns are discarded, and the new fetch starts the same cycle.
- **Simultaneous events:** `line_start` in the cycle the last return lands counts as complete, so no underrun.

## Timing
- `pixstream` latency is 1 cycle from `hread`/`vread`.
- Read issue rate is 1 per `mem_ready` cycle. A full fetch with `mem_ready` held high takes HRES + ⌊(HRES-1)/FETCH_SLICE⌋ + READ_LAT cycles when writes are pending, which is 901 for the defaults.
- A fetch starts 1 cycle after the `hread` transition to 0, since `line_start` is registered on `hread_q`.
- Reset values:
  - All outputs 0.
  - State IDLE, `gen` 0, return pipe invalid.
  - Buffer contents undefined.
- Reset mid-fetch: the pipe clears and no buffer write occurs in the following READ_LAT cycles.

## Structure
- `fb_pkg` holds the HTOTAL (1056) and VTOTAL (628) defaults, the pixel packing field offsets, and the FSM state enum.
- Sub-module `fb_line_buffer`: 2×HRES×DATA_W RAM with one write port and one registered read port. Its read port produces `pixstream`.
- The rest of the logic (FSM, arbiter, return pipe) sits in the top level.

## Test plan
- Reset, then `vread`=0 with `hread` wrapping to 0 → fetch of line 1. First `mem_addr`=800, last =1599. `fetch_busy` drops 800 cycles later with `mem_ready` held high.
- `wr_valid` held high during a fetch → `wr_ready` pulses exactly once after every 8 reads. Memory writes match `wr_addr`/`wr_data`.
- `vread`=627 line start → line 0 fetched into buffer 0. On the next frame, `hread`=5 at `vread`=0 → `pixstream` = memory[5] one cycle later.
- `mem_ready` held low for 600 cycles mid-fetch, then `line_start` → `underrun`=1. Stale returns are not written. The new fetch's first read is at `next_line`*800.
- `vread`=599 line start → no fetch (line 600 ≥ VRES). IDLE persists and writes are granted every `mem_ready` cycle.
- Reset asserted 1 cycle after a read issue → no buffer write, and all outputs 0 the next cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the frame-buffer line scheduler slice:
//   - default raster totals (HTOTAL, VTOTAL) used as parameter defaults
//   - bit offsets of the packed {b, g, r} 4:4:4 pixel fields
//   - line-fetch FSM state encoding
// No ports; imported by fb_line_scheduler.
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int HTOTAL_DEF = 1056;
  localparam int VTOTAL_DEF = 628;

  localparam int PIX_R_LSB = 0;
  localparam int PIX_G_LSB = 4;
  localparam int PIX_B_LSB = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fb_line_buffer.sv
// ---------------------------------------------------------------------------
// fb_line_buffer
// Ping-pong line store: two halves of HRES pixels each. One write port fed
// by returning frame-memory reads, one registered read port that produces
// the display pixel.
// Ports:
//   clk, reset          clock and synchronous active-high reset (read reg only)
//   we, wr_sel, wr_col  write enable, half select, column
//   wr_data             pixel to store
//   rd_sel, rd_col      half select and column for display (column may be
//                       outside the visible range, which reads as 0)
//   rd_data             registered pixel
// ---------------------------------------------------------------------------
module fb_line_buffer #(
  parameter int HRES   = 800,
  parameter int DATA_W = 12,
  parameter int COL_W  = $clog2(HRES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              wr_sel,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_sel,
  input  logic [10:0]       rd_col,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 * HRES;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] ram [DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  // Half 1 sits directly above half 0 in a flat array.
  assign wr_idx = wr_sel ? IDX_W'(HRES) + IDX_W'(wr_col) : IDX_W'(wr_col);
  assign rd_idx = rd_sel ? IDX_W'(HRES) + IDX_W'(rd_col) : IDX_W'(rd_col);

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      ram[wr_idx] <= wr_data;
    end
  end

  // Columns in horizontal blanking read as black.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_col < 11'(HRES)) begin
      rd_data <= ram[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/fb_line_scheduler.sv
// ---------------------------------------------------------------------------
// fb_line_scheduler
// Shares one frame-memory port between the display line prefetcher and the
// incoming stream writer, and feeds the VGA core from a ping-pong line
// buffer. While line N is displayed, line N+1 is fetched into the idle half.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   hread, vread               current raster column / line from VGA core
//   pixstream                  registered pixel for (vread, hread)
//   wr_valid/ready/addr/data   stream write channel
//   mem_ready                  memory accepts a request this cycle
//   mem_req/we/addr/wdata      memory request
//   mem_rdata                  read data, READ_LAT cycles after acceptance
//   fetch_busy                 line fetch in progress
//   underrun                   sticky: a line began before its fetch landed
// ---------------------------------------------------------------------------
module fb_line_scheduler
  import fb_pkg::*;
#(
  parameter int HRES        = 800,
  parameter int VRES        = 600,
  parameter int VTOTAL      = VTOTAL_DEF,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 12,
  parameter int READ_LAT    = 2,
  parameter int FETCH_SLICE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hread,
  input  logic [10:0]       vread,
  output logic [DATA_W-1:0] pixstream,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_busy,
  output logic              underrun
);

  localparam int COL_W = $clog2(HRES + 1);
  localparam int SLC_W = $clog2(FETCH_SLICE + 1);
  localparam int GEN_W = 4;

  typedef struct packed {
    logic             valid;
    logic [GEN_W-1:0] gen;
    logic             dst;
    logic [COL_W-1:0] col;
  } ret_t;

  fetch_state_e     state;
  logic [10:0]      hread_q;
  logic [ADDR_W-1:0] base;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] done_cnt;
  logic             dst;
  logic             active;
  logic [GEN_W-1:0] gen;
  logic [SLC_W-1:0] slice_cnt;
  ret_t             pipe [READ_LAT];

  logic             line_start;
  logic [10:0]      next_line;
  logic             start_ok;
  logic             slice_full;
  logic             read_slot;
  logic             write_slot;
  ret_t             ret_out;
  logic             ret_hit;
  logic [COL_W-1:0] done_now;
  logic             incomplete;

  // Raster decode. hread_q resets to a non-zero value so that a column of 0
  // straight out of reset still counts as a line start.
  assign line_start = (hread == 11'd0) && (hread_q != 11'd0);
  assign next_line  = (vread == 11'(VTOTAL - 1)) ? 11'd0 : vread + 11'd1;
  assign start_ok   = (next_line < 11'(VRES));

  // Slot selection. The slice counter saturates, so once a slice of reads
  // has gone out the first cycle with a pending write takes the slot.
  // All requests are suppressed while reset is held.
  assign slice_full = (slice_cnt == SLC_W'(FETCH_SLICE));
  assign write_slot = !reset && mem_ready &&
                      ((state == IDLE) || (slice_full && wr_valid));
  assign read_slot  = !reset && mem_ready && (state == FETCH) &&
                      !(slice_full && wr_valid);

  // Returns tagged with an older generation belong to an abandoned fetch.
  assign ret_out    = pipe[READ_LAT-1];
  assign ret_hit    = ret_out.valid && (ret_out.gen == gen);

  // A return landing in the same cycle as the line start still counts.
  assign done_now   = done_cnt + COL_W'(ret_hit);
  assign incomplete = active && (done_now < COL_W'(HRES));

  assign fetch_busy = (state == FETCH);

  // Memory port mux. wr_ready reflects the slot only; the memory strobe for
  // a write slot additionally needs a real write so idle slots stay silent.
  always_comb begin
    wr_ready  = write_slot;
    mem_req   = read_slot || (write_slot && wr_valid);
    mem_we    = write_slot && wr_valid;
    mem_addr  = '0;
    mem_wdata = '0;
    if (write_slot) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (read_slot) begin
      mem_addr  = base + ADDR_W'(col);
    end
  end

  // Fetch FSM, return pipe and completion tracking. A line start overrides
  // whatever the current fetch was doing: it either launches the next line
  // or, past the visible area, just abandons an unfinished fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hread_q   <= 11'h7FF;
      base      <= '0;
      col       <= '0;
      dst       <= 1'b0;
      gen       <= '0;
      slice_cnt <= '0;
      done_cnt  <= '0;
      active    <= 1'b0;
      underrun  <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      hread_q <= hread;

      pipe[0] <= '{valid: read_slot, gen: gen, dst: dst, col: col};
      for (int i = 1; i < READ_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end

      if (ret_hit) begin
        done_cnt <= done_now;
        if (done_now == COL_W'(HRES)) begin
          active <= 1'b0;
        end
      end

      if (state == FETCH) begin
        if (read_slot) begin
          col <= col + COL_W'(1);
          if (!slice_full) begin
            slice_cnt <= slice_cnt + SLC_W'(1);
          end
          if (col == COL_W'(HRES - 1)) begin
            state <= IDLE;
          end
        end else if (write_slot) begin
          slice_cnt <= '0;
        end
      end

      if (line_start) begin
        if (incomplete) begin
          underrun <= 1'b1;
        end
        if (start_ok) begin
          state     <= FETCH;
          base      <= ADDR_W'(next_line) * ADDR_W'(HRES);
          col       <= '0;
          dst       <= next_line[0];
          gen       <= gen + GEN_W'(1);
          slice_cnt <= '0;
          done_cnt  <= '0;
          active    <= 1'b1;
        end else if (incomplete) begin
          state    <= IDLE;
          gen      <= gen + GEN_W'(1);
          done_cnt <= '0;
          active   <= 1'b0;
        end
      end
    end
  end

  fb_line_buffer #(
    .HRES   (HRES),
    .DATA_W (DATA_W),
    .COL_W  (COL_W)
  ) u_line_buffer (
    .clk     (clk),
    .reset   (reset),
    .we      (ret_hit && !reset),
    .wr_sel  (ret_out.dst),
    .wr_col  (ret_out.col),
    .wr_data (mem_rdata),
    .rd_sel  (vread[0]),
    .rd_col  (hread),
    .rd_data (pixstream)
  );

endmodule

// File: tb/tb_fb_line_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fb_line_scheduler
// Directed bench for fb_line_scheduler with a small frame-memory model whose
// read data is a fixed function of the address, returned two cycles after
// an accepted read.
// ---------------------------------------------------------------------------
module tb_fb_line_scheduler;
  import fb_pkg::*;

  localparam logic [11:0] SALT = (12'hA << PIX_B_LSB) | (12'h5 << PIX_G_LSB) |
                                 (12'hC << PIX_R_LSB);

  logic        clk;
  logic        reset;
  logic [10:0] hread, vread;
  logic [11:0] pixstream;
  logic        wr_valid, wr_ready;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        mem_ready, mem_req, mem_we;
  logic [18:0] mem_addr;
  logic [11:0] mem_wdata, mem_rdata;
  logic        fetch_busy, underrun;
  logic [11:0] rd1, rd2;

  int checks   = 0;
  int failures = 0;

  fb_line_scheduler dut (
    .clk(clk), .reset(reset), .hread(hread), .vread(vread),
    .pixstream(pixstream), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fetch_busy(fetch_busy), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input logic [18:0] a);
    return a[11:0] ^ SALT;
  endfunction

  // Frame memory: fixed read latency of two cycles.
  always @(posedge clk) begin
    rd1 <= (mem_req && mem_ready && !mem_we) ? pat(mem_addr) : 12'h000;
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; wr_valid = 1'b1;
    wr_addr = 19'h12345; wr_data = 12'hFFF; hread = 11'd0; vread = 11'd0;
    repeat (3) step();
    #1;
    checks++; if (pixstream !== 12'h000) begin $display("[TB] FAIL reset_pix got=%h want=000", pixstream); failures++; end
    checks++; if (wr_ready !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      $display("[TB] FAIL reset_strobes got=%b%b%b want=000", wr_ready, mem_req, mem_we); failures++; end
    checks++; if (mem_addr !== 19'h0 || mem_wdata !== 12'h0) begin
      $display("[TB] FAIL reset_bus got=%h/%h want=0/0", mem_addr, mem_wdata); failures++; end
    checks++; if (fetch_busy !== 1'b0 || underrun !== 1'b0) begin
      $display("[TB] FAIL reset_flags got=%b%b want=00", fetch_busy, underrun); failures++; end
    reset = 1'b0; hread = 11'(HTOTAL_DEF - 1);
    #1;
    checks++; if (wr_ready !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'h12345) begin
      $display("[TB] FAIL idle_write got=%b%b%b %h want=111 12345", wr_ready, mem_req, mem_we, mem_addr); failures++; end
    wr_valid = 1'b0;
  endtask

  task automatic test_fetch();
    int busy, reads;
    logic [18:0] last;
    bit done;
    step(); hread = 11'd0; #1;
    checks++; if (fetch_busy !== 1'b0) begin $display("[TB] FAIL fetch_start_delay got=%b want=0", fetch_busy); failures++; end
    step(); hread = 11'd1; #1;
    checks++; if (fetch_busy !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'd800) begin
      $display("[TB] FAIL fetch_first got=%b%b%b %0d want=110 800", fetch_busy, mem_req, mem_we, mem_addr); failures++; end
    busy = 1; reads = 1; last = mem_addr; done = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      step(); #1;
      if (!fetch_busy) begin done = 1'b1; break; end
      busy++;
      if (mem_req && !mem_we) begin reads++; last = mem_addr; end
    end
    checks++; if (!done) begin $display("[TB] FAIL fetch_timeout got=busy want=idle"); failures++; end
    checks++; if (busy !== 800) begin $display("[TB] FAIL fetch_busy_len got=%0d want=800", busy); failures++; end
    checks++; if (reads !== 800) begin $display("[TB] FAIL fetch_reads got=%0d want=800", reads); failures++; end
    checks++; if (last !== 19'd1599) begin $display("[TB] FAIL fetch_last got=%0d want=1599", last); failures++; end
    repeat (3) step();
    vread = 11'd1; hread = 11'd37;
    step(); #1;
    checks++; if (pixstream !== 12'h919) begin $display("[TB] FAIL pix_l1_c37 got=%h want=919", pixstream); failures++; end
    hread = 11'd799;
    step(); #1;
    checks++; if (pixstream !== 12'hC63) begin $display("[TB] FAIL pix_l1_c799 got=%h want=c63", pixstream); failures++; end
    hread = 11'd800;
    step(); #1;
    checks++; if (pixstream !== 12'h000) begin $display("[TB] FAIL pix_blank got=%h want=000", pixstream); failures++; end
  endtask

  task automatic test_back_to_back();
    int busy, reads, writes, since;
    bit done, acc;
    busy = 0; reads = 0; writes = 0; since = 0; done = 1'b0; acc = 1'b0;
    step(); hread = 11'd0; #1;
    for (int n = 0; n < 1200; n++) begin
      step();
      if (n == 0) begin
        hread = 11'd1; wr_valid = 1'b1; wr_addr = 19'h70000; wr_data = 12'h100;
      end else if (acc) begin
        wr_addr = wr_addr + 19'd1; wr_data = wr_data + 12'd1;
      end
      #1;
      if (!fetch_busy) begin done = 1'b1; break; end
      busy++;
      acc = wr_ready;
      if (wr_ready) begin
        writes++;
        checks++; if (since !== 8) begin $display("[TB] FAIL slice_spacing got=%0d want=8", since); failures++; end
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== wr_addr || mem_wdata !== wr_data) begin
          $display("[TB] FAIL slice_write got=%b%b %h %h want=11 %h %h", mem_req, mem_we, mem_addr, mem_wdata, wr_addr, wr_data); failures++; end
        since = 0;
      end else if (mem_req && !mem_we) begin
        reads++; since++;
      end
    end
    wr_valid = 1'b0;
    checks++; if (!done) begin $display("[TB] FAIL b2b_timeout got=busy want=idle"); failures++; end
    checks++; if (busy !== 899) begin $display("[TB] FAIL b2b_busy_len got=%0d want=899", busy); failures++; end
    checks++; if (reads !== 800) begin $display("[TB] FAIL b2b_reads got=%0d want=800", reads); failures++; end
    checks++; if (writes !== 99) begin $display("[TB] FAIL b2b_writes got=%0d want=99", writes); failures++; end
    repeat (3) step();
    vread = 11'd2; hread = 11'd10;
    step(); #1;
    checks++; if (pixstream !== 12'hC16) begin $display("[TB] FAIL pix_l2_c10 got=%h want=c16", pixstream); failures++; end
  endtask

  task automatic test_wrap();
    bit done;
    done = 1'b0;
    step(); vread = 11'd627; hread = 11'd0; #1;
    step(); hread = 11'd1; #1;
    checks++; if (mem_req !== 1'b1 || fetch_busy !== 1'b1 || mem_addr !== 19'd0) begin
      $display("[TB] FAIL wrap_first got=%b%b %0d want=11 0", mem_req, fetch_busy, mem_addr); failures++; end
    for (int n = 0; n < 1000; n++) begin
      step(); #1;
      if (!fetch_busy) begin done = 1'b1; break; end
    end
    checks++; if (!done) begin $display("[TB] FAIL wrap_timeout got=busy want=idle"); failures++; end
    repeat (3) step();
    vread = 11'd0; hread = 11'd5;
    step(); #1;
    checks++; if (pixstream !== 12'hA59) begin $display("[TB] FAIL pix_l0_c5 got=%h want=a59", pixstream); failures++; end
  endtask

  task automatic test_underrun();
    bit done;
    done = 1'b0;
    step(); vread = 11'd3; hread = 11'd0; #1;
    step(); hread = 11'd1; #1;
    checks++; if (mem_addr !== 19'd3200) begin $display("[TB] FAIL l4_first got=%0d want=3200", mem_addr); failures++; end
    repeat (9) step();
    step(); mem_ready = 1'b0;
    repeat (599) step();
    #1;
    checks++; if (underrun !== 1'b0 || fetch_busy !== 1'b1) begin
      $display("[TB] FAIL stall_flags got=%b%b want=01", underrun, fetch_busy); failures++; end
    step(); mem_ready = 1'b1; #1;
    checks++; if (mem_addr !== 19'd3210) begin $display("[TB] FAIL stall_resume got=%0d want=3210", mem_addr); failures++; end
    step(); vread = 11'd4; hread = 11'd0; #1;
    step(); hread = 11'd1; #1;
    checks++; if (underrun !== 1'b1) begin $display("[TB] FAIL underrun_set got=%b want=1", underrun); failures++; end
    checks++; if (fetch_busy !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'd4000) begin
      $display("[TB] FAIL refetch_first got=%b%b %0d want=10 4000", fetch_busy, mem_we, mem_addr); failures++; end
    repeat (4) step();
    hread = 11'd10;
    step(); #1;
    checks++; if (pixstream !== 12'hA56) begin $display("[TB] FAIL stale_c10 got=%h want=a56", pixstream); failures++; end
    hread = 11'd11;
    step(); #1;
    checks++; if (pixstream !== 12'hA57) begin $display("[TB] FAIL stale_c11 got=%h want=a57", pixstream); failures++; end
    for (int n = 0; n < 1000; n++) begin
      step(); #1;
      if (!fetch_busy) begin done = 1'b1; break; end
    end
    checks++; if (!done) begin $display("[TB] FAIL l5_timeout got=busy want=idle"); failures++; end
    repeat (3) step();
  endtask

  task automatic test_no_fetch();
    step(); vread = 11'd599; hread = 11'd0; #1;
    step(); hread = 11'd1; wr_valid = 1'b1; wr_addr = 19'h7ABCD; wr_data = 12'h3C5; #1;
    checks++; if (fetch_busy !== 1'b0) begin $display("[TB] FAIL vres_no_fetch got=%b want=0", fetch_busy); failures++; end
    checks++; if (wr_ready !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 19'h7ABCD || mem_wdata !== 12'h3C5) begin
      $display("[TB] FAIL vres_write got=%b%b%b %h %h want=111 7abcd 3c5", wr_ready, mem_req, mem_we, mem_addr, mem_wdata); failures++; end
    step(); mem_ready = 1'b0; #1;
    checks++; if (wr_ready !== 1'b0 || mem_req !== 1'b0) begin
      $display("[TB] FAIL no_ready got=%b%b want=00", wr_ready, mem_req); failures++; end
    step(); mem_ready = 1'b1; wr_valid = 1'b0; #1;
    checks++; if (wr_ready !== 1'b1 || mem_req !== 1'b0) begin
      $display("[TB] FAIL idle_slot got=%b%b want=10", wr_ready, mem_req); failures++; end
    checks++; if (underrun !== 1'b1) begin $display("[TB] FAIL underrun_sticky got=%b want=1", underrun); failures++; end
  endtask

  task automatic test_reset_midfetch();
    step(); vread = 11'd5; hread = 11'd0; #1;
    step(); hread = 11'd1; #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 19'd4800) begin
      $display("[TB] FAIL l6_first got=%b %0d want=1 4800", mem_req, mem_addr); failures++; end
    step(); reset = 1'b1; #1;
    step(); #1;
    checks++; if (pixstream !== 12'h0 || fetch_busy !== 1'b0 || underrun !== 1'b0) begin
      $display("[TB] FAIL mid_reset_regs got=%h %b%b want=000 00", pixstream, fetch_busy, underrun); failures++; end
    checks++; if (wr_ready !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 19'h0 || mem_wdata !== 12'h0) begin
      $display("[TB] FAIL mid_reset_bus got=%b%b%b %h %h want=000 0 0", wr_ready, mem_req, mem_we, mem_addr, mem_wdata); failures++; end
    reset = 1'b0; vread = 11'd600; hread = 11'd0;
    step();
    step(); #1;
    checks++; if (pixstream !== 12'h6DC) begin $display("[TB] FAIL no_write_after_reset got=%h want=6dc", pixstream); failures++; end
    checks++; if (fetch_busy !== 1'b0) begin $display("[TB] FAIL post_vres_idle got=%b want=0", fetch_busy); failures++; end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_wrap();
    test_underrun();
    test_no_fetch();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
